counter_prog: RTL and testbench

Parametrised programmable up/down counter, the successor to the fixed-range load/enable counter. Adds a runtime terminal value (`limit`), a variable step, and three modes: wrap, saturate and one-shot. The one-shot mode is sequenced by a small FSM. The block serves as the general-purpose timer/counter primitive for timeout, pacing and burst-length logic across the design.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/counter_prog_if.sv | 32 +++
 rtl/counter_prog.sv | 107 ++++++++++
 tb/tb_counter_prog.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and reset constants for the programmable counter.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } os_state_e;

  localparam os_state_e RST_STATE = OS_IDLE;
  localparam logic      RST_TC    = 1'b0;
  localparam logic      RST_COUNT = 1'b0;

endpackage

// File: rtl/counter_prog_if.sv
// Control/status bundle of counter_prog; master drives controls, slave is the counter.
interface counter_prog_if
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              load_n;
  logic [WIDTH-1:0]  data_load;
  logic              ce;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  mode_e             mode;
  logic              start;
  logic [WIDTH-1:0]  count_out;
  logic              max_count;
  logic              zero;
  logic              tc;
  logic              busy;
  logic              done;

  modport master (
    output load_n, data_load, ce, up_down, step, limit, mode, start,
    input  count_out, max_count, zero, tc, busy, done
  );

  modport slave (
    input  load_n, data_load, ce, up_down, step, limit, mode, start,
    output count_out, max_count, zero, tc, busy, done
  );
endinterface

// File: rtl/counter_prog.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
// Count, tc, busy and done update 1 cycle after their controls; no backpressure, accepts every cycle.
module counter_prog
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  counter_prog_if.slave bus
);

  // One spare bit above the wider of count/step so sums never truncate.
  localparam int CW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
  localparam logic [CW-1:0] ONE_X = {{(CW-1){1'b0}}, 1'b1};

  os_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic [CW-1:0]    cnt_x, lim_x, stp_x, s_x, sum_x;
  logic [WIDTH-1:0] wrap_nxt, sat_nxt, bound;
  logic             wrap_tc, sat_tc, oneshot;

  always_comb begin
    cnt_x = CW'(count_q);
    lim_x = CW'(bus.limit);
    stp_x = CW'(bus.step);
    s_x   = (stp_x > lim_x) ? lim_x : stp_x;
    sum_x = cnt_x + s_x;
    if (bus.up_down) begin
      wrap_tc  = sum_x > lim_x;
      wrap_nxt = wrap_tc ? WIDTH'(sum_x - lim_x - ONE_X) : WIDTH'(sum_x);
      sat_nxt  = (sum_x >= lim_x) ? bus.limit : WIDTH'(sum_x);
      bound    = bus.limit;
    end else begin
      wrap_tc  = cnt_x < s_x;
      wrap_nxt = wrap_tc ? WIDTH'(cnt_x + lim_x + ONE_X - s_x) : WIDTH'(cnt_x - s_x);
      sat_nxt  = (cnt_x <= s_x) ? '0 : WIDTH'(cnt_x - s_x);
      bound    = '0;
    end
    sat_tc = (sat_nxt == bound) && (count_q != bound);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    oneshot = (bus.mode == MODE_ONESHOT);
    if (!bus.load_n) begin
      count_d = (bus.data_load > bus.limit) ? bus.limit : bus.data_load;
      state_d = OS_IDLE;
    end else begin
      // Leaving one-shot mode abandons the sequence; the count is kept that cycle.
      if (!oneshot) state_d = OS_IDLE;
      if (count_q > bus.limit) begin
        count_d = bus.limit;
      end else if (!oneshot) begin
        if (state_q == OS_IDLE && bus.ce) begin
          if (bus.mode == MODE_WRAP) begin
            count_d = wrap_nxt;
            tc_d    = wrap_tc;
          end else begin
            count_d = sat_nxt;
            tc_d    = sat_tc;
          end
        end
      end else begin
        case (state_q)
          OS_IDLE: if (bus.start) state_d = OS_RUN;
          OS_RUN: begin
            if (bus.ce) begin
              count_d = sat_nxt;
              if (sat_nxt == bound) begin
                tc_d    = 1'b1;
                state_d = OS_DONE;
              end
            end
          end
          OS_DONE: if (bus.start) state_d = OS_RUN;
          default: state_d = OS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      count_q <= {WIDTH{RST_COUNT}};
      tc_q    <= RST_TC;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.max_count = (count_q == bus.limit);
  assign bus.zero      = (count_q == '0);
  assign bus.tc        = tc_q;
  assign bus.busy      = (state_q == OS_RUN);
  assign bus.done      = (state_q == OS_DONE);

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench for counter_prog: directed scenarios plus randomized run against a behavioural model.
module tb_counter_prog;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  int   m_cnt = 0;
  int   m_ph  = 0;   // 0 idle, 1 run, 2 done
  bit   m_tc  = 1'b0;

  counter_prog_if #(.WIDTH(8), .STEP_W(4)) bus ();

  counter_prog #(.WIDTH(8), .STEP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_move(input int c, input int s, input int lim, input bit up);
    if (up) return (c + s > lim) ? lim : c + s;
    else    return (c - s < 0) ? 0 : c - s;
  endfunction

  // Reference model: advance one cycle from the inputs seen at this edge.
  always @(posedge clk) begin
    int lim, s, md, nc, bnd;
    lim = int'(bus.limit);
    md  = int'(bus.mode);
    if (rst) begin
      m_cnt = 0; m_ph = 0; m_tc = 0;
    end else if (!bus.load_n) begin
      m_cnt = (int'(bus.data_load) < lim) ? int'(bus.data_load) : lim;
      m_ph  = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      s    = (int'(bus.step) < lim) ? int'(bus.step) : lim;
      bnd  = bus.up_down ? lim : 0;
      if (m_cnt > lim) begin
        m_cnt = lim;
        if (md != 2) m_ph = 0;
      end else if (md != 2) begin
        if (m_ph != 0) m_ph = 0;
        else if (bus.ce) begin
          if (md == 0) begin
            if (bus.up_down) begin
              m_tc  = (m_cnt + s) > lim;
              m_cnt = (m_cnt + s) % (lim + 1);
            end else begin
              m_tc  = m_cnt < s;
              m_cnt = (m_cnt - s + lim + 1) % (lim + 1);
            end
          end else begin
            nc    = sat_move(m_cnt, s, lim, bus.up_down);
            m_tc  = (nc == bnd) && (m_cnt != bnd);
            m_cnt = nc;
          end
        end
      end else begin
        if (m_ph == 0 || m_ph == 2) begin
          if (bus.start) m_ph = 1;
        end else if (bus.ce) begin
          m_cnt = sat_move(m_cnt, s, lim, bus.up_down);
          if (m_cnt == bnd) begin
            m_tc = 1; m_ph = 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model count_out", int'(bus.count_out), m_cnt);
      chk("model tc",        int'(bus.tc),        int'(m_tc));
      chk("model busy",      int'(bus.busy),      int'(m_ph == 1));
      chk("model done",      int'(bus.done),      int'(m_ph == 2));
      chk("model zero",      int'(bus.zero),      int'(m_cnt == 0));
      chk("model max_count", int'(bus.max_count), int'(m_cnt == int'(bus.limit)));
    end
  end

  task automatic do_load(input int v);
    bus.ce = 1'b0; bus.start = 1'b0;
    bus.data_load = 8'(v); bus.load_n = 1'b0;
    tick();
    bus.load_n = 1'b1;
  endtask

  initial begin
    int wu_c[7];
    int wu_t[7];
    int wd_c[4];
    int wd_t[4];
    wu_c = '{3, 6, 9, 2, 5, 8, 1};
    wu_t = '{0, 0, 0, 1, 0, 0, 1};
    wd_c = '{8, 4, 0, 6};
    wd_t = '{1, 0, 0, 1};

    rst = 1'b1;
    bus.load_n = 1'b1; bus.data_load = '0; bus.ce = 1'b0; bus.up_down = 1'b1;
    bus.step = '0; bus.limit = 8'd100; bus.mode = MODE_WRAP; bus.start = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst count", int'(bus.count_out), 0);
    chk("rst zero",  int'(bus.zero), 1);
    chk("rst tc",    int'(bus.tc), 0);
    chk("rst busy",  int'(bus.busy), 0);
    rst = 1'b0;
    do_load(200);
    chk("load clamp count", int'(bus.count_out), 100);
    chk("load clamp max",   int'(bus.max_count), 1);

    bus.limit = 8'd9;
    do_load(0);
    bus.step = 4'd3; bus.up_down = 1'b1; bus.ce = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("wrap up count", int'(bus.count_out), wu_c[i]);
      chk("wrap up tc",    int'(bus.tc), wu_t[i]);
    end

    do_load(2);
    bus.step = 4'd4; bus.up_down = 1'b0; bus.ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap dn count", int'(bus.count_out), wd_c[i]);
      chk("wrap dn tc",    int'(bus.tc), wd_t[i]);
    end

    bus.mode = MODE_SAT; bus.limit = 8'd255;
    do_load(250);
    bus.step = 4'd15; bus.up_down = 1'b1; bus.ce = 1'b1;
    tick();
    chk("sat hit count", int'(bus.count_out), 255);
    chk("sat hit tc",    int'(bus.tc), 1);
    tick();
    chk("sat hold tc",   int'(bus.tc), 0);
    bus.up_down = 1'b0; bus.step = 4'd0;
    tick();
    chk("sat step0 count", int'(bus.count_out), 255);

    bus.mode = MODE_ONESHOT;
    do_load(3);
    bus.step = 4'd1; bus.up_down = 1'b0; bus.start = 1'b1; bus.ce = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("os start busy",  int'(bus.busy), 1);
    chk("os start count", int'(bus.count_out), 3);
    for (int v = 2; v >= 0; v--) begin
      tick();
      chk("os run count", int'(bus.count_out), v);
    end
    chk("os end tc",   int'(bus.tc), 1);
    chk("os end done", int'(bus.done), 1);
    tick();
    chk("os frozen count", int'(bus.count_out), 0);
    chk("os frozen tc",    int'(bus.tc), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("os restart busy", int'(bus.busy), 1);
    tick();
    chk("os restart tc",   int'(bus.tc), 1);
    chk("os restart done", int'(bus.done), 1);

    bus.mode = MODE_WRAP; bus.limit = 8'd50;
    do_load(40);
    bus.limit = 8'd10;
    tick();
    chk("limit drop count", int'(bus.count_out), 10);
    chk("limit drop tc",    int'(bus.tc), 0);

    bus.mode = MODE_ONESHOT; bus.limit = 8'd50;
    do_load(20);
    bus.step = 4'd1; bus.up_down = 1'b1; bus.start = 1'b1; bus.ce = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("pre-rst count", int'(bus.count_out), 21);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-run rst busy",  int'(bus.busy), 0);
    chk("mid-run rst count", int'(bus.count_out), 0);

    bus.mode = MODE_ONESHOT;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.load_n = ($urandom_range(0, 15) != 0);
      bus.data_load = 8'($urandom);
      bus.ce = ($urandom_range(0, 3) != 0);
      bus.up_down = 1'($urandom);
      bus.step = 4'($urandom);
      if ($urandom_range(0, 31) == 0)
        bus.limit = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      if ($urandom_range(0, 47) == 0) bus.mode = mode_e'(2'($urandom));
      bus.start = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
